// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_pkg
// Purpose  : AT043TN25 default raster constants, shared types and helpers.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package lcd_timing_pkg;

    localparam int c_at043_h_active = 480;
    localparam int c_at043_h_fp     = 2;
    localparam int c_at043_h_sync   = 41;
    localparam int c_at043_h_bp     = 2;
    localparam int c_at043_v_active = 272;
    localparam int c_at043_v_fp     = 2;
    localparam int c_at043_v_sync   = 10;
    localparam int c_at043_v_bp     = 2;
    localparam int c_at043_clk_div  = 4;
    localparam int c_at043_col_w    = 9;
    localparam int c_at043_row_w    = 9;

    typedef enum logic {
        SYNC_DE_ONLY = 1'b0,
        SYNC_DE_HV   = 1'b1
    } sync_mode_e;

    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } lcd_ctrl_t;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width able to hold 0..count-1, never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_pclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pclk_gen
// Purpose  : Divides i_clk into a 50% duty pixel clock plus a one-cycle enable.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module lcd_pclk_gen
    import lcd_timing_pkg::*;
#(
    parameter int CLK_DIV = c_at043_clk_div
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_clk,
    output logic o_pix_en
);

    localparam int c_dw = cnt_width(CLK_DIV);
    localparam logic [c_dw-1:0] c_cnt_last = c_dw'(CLK_DIV - 1);
    localparam logic [c_dw-1:0] c_cnt_half = c_dw'(CLK_DIV / 2);

    generate
        if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
            $fatal(1, "lcd_pclk_gen: CLK_DIV must be even and at least 2");
        end
    endgenerate

    logic [c_dw-1:0] r_cnt;
    logic            r_clk;
    logic            r_pix_en;
    logic            w_cnt_last;

    assign w_cnt_last = (r_cnt == c_cnt_last);

    // o_pix_en lands in the last high cycle of o_clk, so consumers update on the falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_clk    <= 1'b0;
            r_pix_en <= 1'b0;
        end else if (!i_enable) begin
            r_cnt    <= '0;
            r_clk    <= 1'b0;
            r_pix_en <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_last ? '0 : r_cnt + c_dw'(1);
            r_clk    <= (r_cnt >= c_cnt_half);
            r_pix_en <= w_cnt_last;
        end
    end

    assign o_clk    = r_clk;
    assign o_pix_en = r_pix_en;

endmodule
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_gen
// Purpose  : RGB parallel panel raster generator: pixel clock, DE, H/VSYNC,
//            active coordinates and line/frame strobes.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_at043_h_active,
    parameter int H_FP     = c_at043_h_fp,
    parameter int H_SYNC   = c_at043_h_sync,
    parameter int H_BP     = c_at043_h_bp,
    parameter int V_ACTIVE = c_at043_v_active,
    parameter int V_FP     = c_at043_v_fp,
    parameter int V_SYNC   = c_at043_v_sync,
    parameter int V_BP     = c_at043_v_bp,
    parameter int CLK_DIV  = c_at043_clk_div,
    parameter bit SYNC_POL = 1'b0,
    parameter int COL_W    = c_at043_col_w,
    parameter int ROW_W    = c_at043_row_w
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_sync_mode,
    output logic             o_clk,
    output logic             o_pix_en,
    output logic             o_data_enable,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_line_start,
    output logic             o_frame_start
);

    localparam int c_h_total = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_hw      = cnt_width(c_h_total);
    localparam int c_vw      = cnt_width(c_v_total);

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_act_end  = c_hw'(H_ACTIVE);
    localparam logic [c_hw-1:0] c_hs_first   = c_hw'(H_ACTIVE + H_FP);
    localparam logic [c_hw-1:0] c_hs_last    = c_hw'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_act_end  = c_vw'(V_ACTIVE);
    localparam logic [c_vw-1:0] c_vs_first   = c_vw'(V_ACTIVE + V_FP);
    localparam logic [c_vw-1:0] c_vs_last    = c_vw'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam lcd_ctrl_t c_ctrl_idle = '{
        de:          1'b0,
        hsync:       ~SYNC_POL,
        vsync:       ~SYNC_POL,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    generate
        if (H_ACTIVE > (1 << COL_W)) begin : g_bad_col_w
            $fatal(1, "lcd_timing_gen: COL_W cannot hold H_ACTIVE-1");
        end
        if (V_ACTIVE > (1 << ROW_W)) begin : g_bad_row_w
            $fatal(1, "lcd_timing_gen: ROW_W cannot hold V_ACTIVE-1");
        end
        if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_geometry
            $fatal(1, "lcd_timing_gen: active and sync widths must be at least 1");
        end
    endgenerate

    logic             w_pix_en;
    logic             w_pclk;

    logic [c_hw-1:0]  r_h;
    logic [c_vw-1:0]  r_v;
    sync_mode_e       r_mode;
    lcd_ctrl_t        r_ctrl;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic             w_h_last;
    logic             w_v_last;
    logic             w_origin;
    sync_mode_e       w_mode;
    logic             w_de;
    logic             w_hs_act;
    logic             w_vs_act;
    lcd_ctrl_t        w_ctrl_nxt;

    lcd_pclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pclk_gen (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .o_clk    (w_pclk),
        .o_pix_en (w_pix_en)
    );

    assign w_h_last = (r_h == c_h_last);
    assign w_v_last = (r_v == c_v_last);
    assign w_origin = (r_h == '0) && (r_v == '0);
    // The first pixel of a frame already follows the freshly sampled mode.
    assign w_mode   = w_origin ? sync_mode_e'(i_sync_mode) : r_mode;
    assign w_de     = (r_h < c_h_act_end) && (r_v < c_v_act_end);
    assign w_hs_act = (w_mode == SYNC_DE_HV) && (r_h >= c_hs_first) && (r_h <= c_hs_last);
    assign w_vs_act = (w_mode == SYNC_DE_HV) && (r_v >= c_vs_first) && (r_v <= c_vs_last);

    always_comb begin
        w_ctrl_nxt             = c_ctrl_idle;
        w_ctrl_nxt.de          = w_de;
        w_ctrl_nxt.line_start  = (r_h == '0);
        w_ctrl_nxt.frame_start = w_origin;
        if (w_hs_act) begin
            w_ctrl_nxt.hsync = SYNC_POL;
        end
        if (w_vs_act) begin
            w_ctrl_nxt.vsync = SYNC_POL;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h    <= '0;
            r_v    <= '0;
            r_mode <= SYNC_DE_ONLY;
        end else if (!i_enable) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_en) begin
            if (w_origin) begin
                r_mode <= w_mode;
            end
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + c_vw'(1);
            end else begin
                r_h <= r_h + c_hw'(1);
            end
        end
    end

    // Outputs describe the pixel the counters pointed at before this advance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ctrl <= c_ctrl_idle;
            r_col  <= '0;
            r_row  <= '0;
        end else if (!i_enable) begin
            r_ctrl <= c_ctrl_idle;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_pix_en) begin
            r_ctrl <= w_ctrl_nxt;
            r_col  <= w_de ? COL_W'(r_h) : '0;
            r_row  <= w_de ? ROW_W'(r_v) : '0;
        end
    end

    assign o_clk         = w_pclk;
    assign o_pix_en      = w_pix_en;
    assign o_data_enable = r_ctrl.de;
    assign o_hsync       = r_ctrl.hsync;
    assign o_vsync       = r_ctrl.vsync;
    assign o_line_start  = r_ctrl.line_start;
    assign o_frame_start = r_ctrl.frame_start;
    assign o_col         = r_col;
    assign o_row         = r_row;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lcd_timing_gen
// Purpose  : Directed checks of two small raster geometries sharing one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_gen;

    logic clk;
    logic rst;
    logic enable;
    logic sync_mode;

    int checks;
    int failures;

    // Small geometry: CLK_DIV=2, 8x4 active, porches 1, syncs 2, active-low syncs.
    logic       s_clk, s_pen, s_de, s_hs, s_vs, s_ls, s_fs;
    logic [2:0] s_col;
    logic [1:0] s_row;
    // Second geometry: CLK_DIV=4, 16x6 active, active-high syncs, exact-fit widths.
    logic       b_clk, b_pen, b_de, b_hs, b_vs, b_ls, b_fs;
    logic [3:0] b_col;
    logic [2:0] b_row;

    logic [22:0] s_obs;
    logic [22:0] b_obs;
    logic [9:0]  s_grp;
    logic [4:0]  b_grp;

    assign s_obs = {s_clk, s_pen, s_de, s_hs, s_vs, s_ls, s_fs, {5'b0, s_col}, {6'b0, s_row}};
    assign b_obs = {b_clk, b_pen, b_de, b_hs, b_vs, b_ls, b_fs, {4'b0, b_col}, {5'b0, b_row}};
    assign s_grp = {s_de, s_hs, s_vs, s_ls, s_fs, s_col, s_row};
    assign b_grp = {b_clk, b_pen, b_de, b_hs, b_fs};

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SYNC_POL(1'b0), .COL_W(3), .ROW_W(2)
    ) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_sync_mode(sync_mode),
        .o_clk(s_clk), .o_pix_en(s_pen), .o_data_enable(s_de),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_col(s_col), .o_row(s_row),
        .o_line_start(s_ls), .o_frame_start(s_fs)
    );

    lcd_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(4), .SYNC_POL(1'b1), .COL_W(4), .ROW_W(3)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_sync_mode(sync_mode),
        .o_clk(b_clk), .o_pix_en(b_pen), .o_data_enable(b_de),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_col(b_col), .o_row(b_row),
        .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    always #5 clk = ~clk;

    // Expected outputs k i_clk edges after enable rose (k<0: fully idle).
    // Pixel p is shown from edge d+p*d; h/v are derived from the pixel index.
    function automatic logic [22:0] exp_vec(input int k, input int d,
                                            input int ha, input int hfp, input int hsw, input int hbp,
                                            input int va, input int vfp, input int vsw, input int vbp,
                                            input bit pol, input bit mode);
        int ht, vt, p, h, v;
        logic c, pe, de, hs, vs, ls, fs;
        logic [7:0] col, row;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        c = 1'b0; pe = 1'b0; de = 1'b0; hs = ~pol; vs = ~pol; ls = 1'b0; fs = 1'b0;
        col = 8'd0; row = 8'd0;
        if (k >= 0) begin
            c  = ((k % d) >= d / 2);
            pe = ((k % d) == d - 1);
        end
        if (k >= d) begin
            p  = (k - d) / d;
            h  = p % ht;
            v  = (p / ht) % vt;
            de = (h < ha) && (v < va);
            if (mode && h >= ha + hfp && h < ha + hfp + hsw) hs = pol;
            if (mode && v >= va + vfp && v < va + vfp + vsw) vs = pol;
            ls = (h == 0);
            fs = (h == 0) && (v == 0);
            if (de) begin
                col = 8'(h);
                row = 8'(v);
            end
        end
        return {c, pe, de, hs, vs, ls, fs, col, row};
    endfunction

    function automatic logic [22:0] exp_s(input int k, input bit mode);
        return exp_vec(k, 2, 8, 1, 2, 1, 4, 1, 2, 1, 1'b0, mode);
    endfunction

    function automatic logic [22:0] exp_b(input int k, input bit mode);
        return exp_vec(k, 4, 16, 2, 3, 2, 6, 1, 2, 1, 1'b1, mode);
    endfunction

    // Park both generators, then raise enable; the next posedge is edge 0.
    task automatic restart(input bit mode);
        @(negedge clk);
        enable    = 1'b0;
        sync_mode = mode;
        repeat (2) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (s_obs !== exp_s(-1, 1'b0)) begin
            failures++;
            $display("FAIL reset_s got=%h exp=%h", s_obs, exp_s(-1, 1'b0));
        end
        checks++;
        if (b_obs !== exp_b(-1, 1'b0)) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", b_obs, exp_b(-1, 1'b0));
        end
        enable    = 1'b1;
        sync_mode = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_obs !== exp_s(-1, 1'b0)) begin
            failures++;
            $display("FAIL reset_hold_s got=%h exp=%h", s_obs, exp_s(-1, 1'b0));
        end
        checks++;
        if (b_obs !== exp_b(-1, 1'b0)) begin
            failures++;
            $display("FAIL reset_hold_b got=%h exp=%h", b_obs, exp_b(-1, 1'b0));
        end
        enable = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_de_only();
        bit sm, bm;
        sm = 1'b0; bm = 1'b0;
        restart(1'b0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 96 == 0) sm = sync_mode;
            if (k >= 4 && k % 4 == 0 && ((k - 4) / 4) % 230 == 0) bm = sync_mode;
            checks++;
            if (s_obs !== exp_s(k, sm)) begin
                failures++;
                $display("FAIL de_only_s k=%0d got=%h exp=%h", k, s_obs, exp_s(k, sm));
            end
            checks++;
            if (b_obs !== exp_b(k, bm)) begin
                failures++;
                $display("FAIL de_only_b k=%0d got=%h exp=%h", k, b_obs, exp_b(k, bm));
            end
        end
    endtask

    task automatic test_sync_mode();
        bit sm, bm;
        sm = 1'b0; bm = 1'b0;
        restart(1'b1);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 96 == 0) sm = sync_mode;
            if (k >= 4 && k % 4 == 0 && ((k - 4) / 4) % 230 == 0) bm = sync_mode;
            checks++;
            if (s_obs !== exp_s(k, sm)) begin
                failures++;
                $display("FAIL sync_mode_s k=%0d got=%h exp=%h", k, s_obs, exp_s(k, sm));
            end
            checks++;
            if (b_obs !== exp_b(k, bm)) begin
                failures++;
                $display("FAIL sync_mode_b k=%0d got=%h exp=%h", k, b_obs, exp_b(k, bm));
            end
        end
    endtask

    // Hand-derived waveform points: small {de,hs,vs,ls,fs,col,row}, second {clk,pen,de,hs,fs}.
    task automatic test_directed();
        logic [9:0] es;
        logic [4:0] eb;
        bit do_s, do_b;
        restart(1'b1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            do_s = 1'b1;
            es   = '0;
            case (k)
                2:       es = 10'b1_1_1_1_1_000_00;
                16:      es = 10'b1_1_1_0_0_111_00;
                18:      es = 10'b0_1_1_0_0_000_00;
                20:      es = 10'b0_0_1_0_0_000_00;
                24:      es = 10'b0_1_1_0_0_000_00;
                26:      es = 10'b1_1_1_1_0_000_01;
                88:      es = 10'b1_1_1_0_0_111_11;
                98:      es = 10'b0_1_1_1_0_000_00;
                122:     es = 10'b0_1_0_1_0_000_00;
                170:     es = 10'b0_1_1_1_0_000_00;
                194:     es = 10'b1_1_1_1_1_000_00;
                default: do_s = 1'b0;
            endcase
            if (do_s) begin
                checks++;
                if (s_grp !== es) begin
                    failures++;
                    $display("FAIL directed_s k=%0d got=%b exp=%b", k, s_grp, es);
                end
            end
            do_b = 1'b1;
            eb   = '0;
            case (k)
                0:       eb = 5'b00000;
                2:       eb = 5'b10000;
                3:       eb = 5'b11000;
                4:       eb = 5'b00101;
                76:      eb = 5'b00010;
                84:      eb = 5'b00010;
                88:      eb = 5'b00000;
                default: do_b = 1'b0;
            endcase
            if (do_b) begin
                checks++;
                if (b_grp !== eb) begin
                    failures++;
                    $display("FAIL directed_b k=%0d got=%b exp=%b", k, b_grp, eb);
                end
            end
        end
    endtask

    // Mode flips mid-frame; each generator must keep the old mode until its next frame.
    task automatic test_mode_toggle();
        bit sm, bm;
        sm = 1'b0; bm = 1'b0;
        restart(1'b0);
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 96 == 0) sm = sync_mode;
            if (k >= 4 && k % 4 == 0 && ((k - 4) / 4) % 230 == 0) bm = sync_mode;
            checks++;
            if (s_obs !== exp_s(k, sm)) begin
                failures++;
                $display("FAIL toggle_s k=%0d got=%h exp=%h", k, s_obs, exp_s(k, sm));
            end
            checks++;
            if (b_obs !== exp_b(k, bm)) begin
                failures++;
                $display("FAIL toggle_b k=%0d got=%h exp=%h", k, b_obs, exp_b(k, bm));
            end
            if (k == 300) sync_mode = 1'b1;
        end
    endtask

    task automatic test_enable_drop();
        bit sm, bm;
        sm = 1'b0; bm = 1'b0;
        restart(1'b0);
        repeat (250) @(negedge clk);
        enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (s_obs !== exp_s(-1, 1'b0)) begin
                failures++;
                $display("FAIL enable_low_s j=%0d got=%h exp=%h", j, s_obs, exp_s(-1, 1'b0));
            end
            checks++;
            if (b_obs !== exp_b(-1, 1'b0)) begin
                failures++;
                $display("FAIL enable_low_b j=%0d got=%h exp=%h", j, b_obs, exp_b(-1, 1'b0));
            end
        end
        sync_mode = 1'b1;
        enable    = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 96 == 0) sm = sync_mode;
            if (k >= 4 && k % 4 == 0 && ((k - 4) / 4) % 230 == 0) bm = sync_mode;
            checks++;
            if (s_obs !== exp_s(k, sm)) begin
                failures++;
                $display("FAIL reenable_s k=%0d got=%h exp=%h", k, s_obs, exp_s(k, sm));
            end
            checks++;
            if (b_obs !== exp_b(k, bm)) begin
                failures++;
                $display("FAIL reenable_b k=%0d got=%h exp=%h", k, b_obs, exp_b(k, bm));
            end
        end
    endtask

    // Reset lands between edges at small h=5,v=2; outputs must clear before the next edge.
    task automatic test_async_reset();
        bit sm, bm;
        sm = 1'b0; bm = 1'b0;
        restart(1'b0);
        repeat (61) @(negedge clk);
        checks++;
        if (s_grp !== 10'b1_1_1_0_0_101_10) begin
            failures++;
            $display("FAIL pre_reset_s got=%b exp=%b", s_grp, 10'b1_1_1_0_0_101_10);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s_obs !== exp_s(-1, 1'b0)) begin
            failures++;
            $display("FAIL async_reset_s got=%h exp=%h", s_obs, exp_s(-1, 1'b0));
        end
        checks++;
        if (b_obs !== exp_b(-1, 1'b0)) begin
            failures++;
            $display("FAIL async_reset_b got=%h exp=%h", b_obs, exp_b(-1, 1'b0));
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k >= 2 && k % 2 == 0 && ((k - 2) / 2) % 96 == 0) sm = sync_mode;
            if (k >= 4 && k % 4 == 0 && ((k - 4) / 4) % 230 == 0) bm = sync_mode;
            checks++;
            if (s_obs !== exp_s(k, sm)) begin
                failures++;
                $display("FAIL post_reset_s k=%0d got=%h exp=%h", k, s_obs, exp_s(k, sm));
            end
            checks++;
            if (b_obs !== exp_b(k, bm)) begin
                failures++;
                $display("FAIL post_reset_b k=%0d got=%h exp=%h", k, b_obs, exp_b(k, bm));
            end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        enable    = 1'b0;
        sync_mode = 1'b0;
        checks    = 0;
        failures  = 0;
        test_reset();
        test_de_only();
        test_sync_mode();
        test_directed();
        test_mode_toggle();
        test_enable_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
